// File: rtl/dcba_step_counter.sv
// dcba_step_counter: 4-bit up/down modulo-MOD code generator with prescaled
// run mode, single-step, synchronous load and a one-cycle wrap pulse.
// dcba is taken straight from a flop so the combinational Gray converter
// downstream never sees glitches.
module dcba_step_counter #(
    parameter int MOD = 16,
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] dcba,
    output logic       tc,
    output logic       busy
);

    localparam int            PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [3:0]    TOP   = 4'(MOD - 1);
    localparam logic [4:0]    MODW  = 5'(MOD);
    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SINGLE
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] psc, psc_nx;
    logic [3:0]    dcba_nx;
    logic          tc_nx;
    logic          advance;

    // Next-state logic: start beats step in IDLE, stop beats start in RUN,
    // SINGLE always lasts one cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start)     state_nx = RUN;
                else if (step) state_nx = SINGLE;
            end
            RUN: begin
                if (stop)      state_nx = IDLE;
            end
            SINGLE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: load overrides any advance; prescaler only runs while staying in RUN.
    always_comb begin
        advance = ((state == RUN) && (psc == PLAST)) || (state == SINGLE);
        dcba_nx = dcba;
        tc_nx   = 1'b0;
        psc_nx  = '0;
        if (load) begin
            dcba_nx = ({1'b0, load_val} < MODW) ? load_val : TOP;
        end else begin
            if (advance) begin
                if (up) begin
                    if (dcba == TOP) begin
                        dcba_nx = '0;
                        tc_nx   = 1'b1;
                    end else begin
                        dcba_nx = dcba + 4'd1;
                    end
                end else begin
                    if (dcba == '0) begin
                        dcba_nx = TOP;
                        tc_nx   = 1'b1;
                    end else begin
                        dcba_nx = dcba - 4'd1;
                    end
                end
            end
            if ((state == RUN) && (state_nx == RUN)) begin
                psc_nx = (psc == PLAST) ? '0 : psc + PW'(1);
            end
        end
    end

    // State and output registers; busy mirrors next-state==RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            psc   <= '0;
            dcba  <= '0;
            tc    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            psc   <= psc_nx;
            dcba  <= dcba_nx;
            tc    <= tc_nx;
            busy  <= (state_nx == RUN);
        end
    end

endmodule

// File: tb/tb_dcba_step_counter.sv
// Testbench for dcba_step_counter: four parameterisations driven from shared
// inputs, each checked against a cycle-level arithmetic reference model.
module tb_dcba_step_counter;

    localparam int NI = 4;

    logic       clk;
    logic       rst_n;
    logic       start, stop, step, up, load;
    logic [3:0] load_val;
    logic [3:0] d_o [NI];
    logic       t_o [NI];
    logic       b_o [NI];

    int mods [NI] = '{16, 10, 16, 2};
    int divs [NI] = '{1, 4, 3, 1};

    // Reference model: mode 0 = idle, 1 = running, 2 = single step
    int m_d    [NI];
    int m_tc   [NI];
    int m_busy [NI];
    int m_mode [NI];
    int m_cnt  [NI];

    int passed = 0;
    int total  = 0;

    dcba_step_counter #(.MOD(16), .DIV(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step), .up(up),
        .load(load), .load_val(load_val), .dcba(d_o[0]), .tc(t_o[0]), .busy(b_o[0]));
    dcba_step_counter #(.MOD(10), .DIV(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step), .up(up),
        .load(load), .load_val(load_val), .dcba(d_o[1]), .tc(t_o[1]), .busy(b_o[1]));
    dcba_step_counter #(.MOD(16), .DIV(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step), .up(up),
        .load(load), .load_val(load_val), .dcba(d_o[2]), .tc(t_o[2]), .busy(b_o[2]));
    dcba_step_counter #(.MOD(2), .DIV(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step), .up(up),
        .load(load), .load_val(load_val), .dcba(d_o[3]), .tc(t_o[3]), .busy(b_o[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_d[k] = 0; m_tc[k] = 0; m_busy[k] = 0; m_mode[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            int adv, nm;
            adv = ((m_mode[k] == 1) && (m_cnt[k] == divs[k] - 1)) || (m_mode[k] == 2);
            if (m_mode[k] == 0)      nm = start ? 1 : (step ? 2 : 0);
            else if (m_mode[k] == 1) nm = stop ? 0 : 1;
            else                     nm = 0;
            if (load) begin
                m_d[k]   = (int'(load_val) < mods[k]) ? int'(load_val) : mods[k] - 1;
                m_tc[k]  = 0;
                m_cnt[k] = 0;
            end else begin
                m_tc[k] = 0;
                if (adv != 0) begin
                    if (up) begin
                        m_tc[k] = (m_d[k] == mods[k] - 1) ? 1 : 0;
                        m_d[k]  = (m_d[k] + 1) % mods[k];
                    end else begin
                        m_tc[k] = (m_d[k] == 0) ? 1 : 0;
                        m_d[k]  = (m_d[k] + mods[k] - 1) % mods[k];
                    end
                end
                m_cnt[k] = (m_mode[k] == 1 && nm == 1) ? (m_cnt[k] + 1) % divs[k] : 0;
            end
            m_busy[k] = (nm == 1) ? 1 : 0;
            m_mode[k] = nm;
        end
    endtask

    // One clock: model follows the inputs seen at the edge, then settle 1 time unit.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic go_idle();
        start = 0; step = 0; load = 0; stop = 1;
        tick();
        tick();
        stop = 0;
    endtask

    task automatic test_reset();
        start = 0; stop = 0; step = 0; up = 1; load = 0; load_val = '0;
        rst_n = 1;
        #2 rst_n = 0;
        model_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            total++;
            if (d_o[k] !== 4'd0 || t_o[k] !== 1'b0 || b_o[k] !== 1'b0)
                $display("FAIL reset inst%0d: dcba=%0d tc=%b busy=%b required 0/0/0", k, d_o[k], t_o[k], b_o[k]);
            else passed++;
        end
        tick();
        rst_n = 1;
        tick();
        for (int k = 0; k < NI; k++) begin
            total++;
            if (d_o[k] !== 4'd0 || b_o[k] !== 1'b0)
                $display("FAIL reset_idle inst%0d: dcba=%0d busy=%b required 0/0", k, d_o[k], b_o[k]);
            else passed++;
        end
    endtask

    task automatic test_free_run();
        int tcs;
        tcs = 0;
        up = 1; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 17; i++) begin
            total++;
            if (d_o[0] !== 4'(i % 16) || b_o[0] !== 1'b1)
                $display("FAIL free_run cyc%0d: dcba=%0d busy=%b required %0d/1", i, d_o[0], b_o[0], i % 16);
            else passed++;
            total++;
            if (t_o[0] !== ((i == 16) ? 1'b1 : 1'b0))
                $display("FAIL free_run_tc cyc%0d: tc=%b required %b", i, t_o[0], (i == 16));
            else passed++;
            if (t_o[0] === 1'b1) tcs++;
            tick();
        end
        total++;
        if (tcs != 1) $display("FAIL free_run_tc_count: %0d pulses required 1", tcs);
        else passed++;
        go_idle();
    endtask

    task automatic test_prescaled_down();
        int tcs;
        tcs = 0;
        load_val = 4'd2; load = 1;
        tick();
        load = 0; up = 0; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 20; i++) begin
            int exp_v;
            exp_v = (2 - i / 4 + 10) % 10;
            total++;
            if (d_o[1] !== 4'(exp_v) || int'(d_o[1]) != m_d[1])
                $display("FAIL prescaled_down cyc%0d: dcba=%0d required %0d", i, d_o[1], exp_v);
            else passed++;
            total++;
            if (int'(t_o[1]) != m_tc[1])
                $display("FAIL prescaled_down_tc cyc%0d: tc=%b required %0d", i, t_o[1], m_tc[1]);
            else passed++;
            if (t_o[1] === 1'b1) tcs++;
            tick();
        end
        total++;
        if (tcs != 1) $display("FAIL prescaled_tc_count: %0d pulses required 1", tcs);
        else passed++;
        go_idle();
    endtask

    task automatic test_single_step();
        up = 1; load_val = 4'd5; load = 1;
        tick();
        load = 0; step = 1;
        tick();
        step = 0;
        tick();
        total++;
        if (d_o[0] !== 4'd6 || b_o[0] !== 1'b0)
            $display("FAIL single_step: dcba=%0d busy=%b required 6/0", d_o[0], b_o[0]);
        else passed++;
        tick();
        total++;
        if (d_o[0] !== 4'd6)
            $display("FAIL single_step_idle: dcba=%0d required 6", d_o[0]);
        else passed++;
        step = 1;
        for (int i = 0; i < 4; i++) tick();
        step = 0;
        tick();
        tick();
        total++;
        if (d_o[0] !== 4'd8 || b_o[0] !== 1'b0)
            $display("FAIL step_held: dcba=%0d busy=%b required 8/0", d_o[0], b_o[0]);
        else passed++;
        for (int k = 0; k < NI; k++) begin
            total++;
            if (int'(d_o[k]) != m_d[k])
                $display("FAIL step_model inst%0d: dcba=%0d required %0d", k, d_o[k], m_d[k]);
            else passed++;
        end
    endtask

    task automatic test_priority();
        logic [3:0] frozen;
        int found;
        start = 1; stop = 1;
        tick();
        total++;
        if (b_o[0] !== 1'b1) $display("FAIL prio_start_over_stop: busy=%b required 1", b_o[0]);
        else passed++;
        tick();
        total++;
        if (b_o[0] !== 1'b0) $display("FAIL prio_stop_over_start: busy=%b required 0", b_o[0]);
        else passed++;
        start = 0; stop = 0;
        frozen = d_o[0];
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (d_o[0] !== frozen || int'(d_o[0]) != m_d[0])
                $display("FAIL prio_frozen cyc%0d: dcba=%0d required %0d", i, d_o[0], frozen);
            else passed++;
        end
        up = 1; start = 1;
        tick();
        start = 0;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            if (m_mode[1] == 1 && m_cnt[1] == divs[1] - 1) found = 1;
            else tick();
        end
        total++;
        if (found == 0) $display("FAIL prio_tick_wait: tick not reached required within 12 cycles");
        else passed++;
        load_val = 4'd13; load = 1;
        tick();
        load = 0;
        total++;
        if (d_o[1] !== 4'd9 || t_o[1] !== 1'b0 || b_o[1] !== 1'b1)
            $display("FAIL prio_load_over_tick: dcba=%0d tc=%b busy=%b required 9/0/1", d_o[1], t_o[1], b_o[1]);
        else passed++;
        go_idle();
    endtask

    task automatic test_async_reset();
        up = 1; load_val = 4'd7; load = 1;
        tick();
        load = 0; start = 1;
        tick();
        start = 0;
        tick();
        tick();
        #3 rst_n = 0;
        model_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            total++;
            if (d_o[k] !== 4'd0 || t_o[k] !== 1'b0 || b_o[k] !== 1'b0)
                $display("FAIL async_reset inst%0d: dcba=%0d tc=%b busy=%b required 0/0/0", k, d_o[k], t_o[k], b_o[k]);
            else passed++;
        end
        tick();
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (d_o[2] !== 4'd0 || b_o[2] !== 1'b0)
                $display("FAIL async_release cyc%0d: dcba=%0d busy=%b required 0/0", i, d_o[2], b_o[2]);
            else passed++;
        end
    endtask

    task automatic test_wrap_mod2();
        int tcs;
        tcs = 0;
        load_val = 4'd0; load = 1;
        tick();
        load = 0; up = 1; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (d_o[3] !== 4'(i % 2) || t_o[3] !== ((i > 0 && i % 2 == 0) ? 1'b1 : 1'b0))
                $display("FAIL wrap_mod2 cyc%0d: dcba=%0d tc=%b required %0d/%0d",
                         i, d_o[3], t_o[3], i % 2, (i > 0 && i % 2 == 0));
            else passed++;
            if (t_o[3] === 1'b1) tcs++;
            tick();
        end
        total++;
        if (tcs != 3) $display("FAIL wrap_mod2_count: %0d pulses required 3", tcs);
        else passed++;
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 19) == 0);
            step     = ($urandom_range(0, 4) == 0);
            up       = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 24) == 0);
            load_val = 4'($urandom_range(0, 15));
            tick();
            for (int k = 0; k < NI; k++) begin
                total++;
                if (int'(d_o[k]) != m_d[k] || int'(t_o[k]) != m_tc[k] || int'(b_o[k]) != m_busy[k])
                    $display("FAIL random cyc%0d inst%0d: dcba=%0d tc=%b busy=%b required %0d/%0d/%0d",
                             i, k, d_o[k], t_o[k], b_o[k], m_d[k], m_tc[k], m_busy[k]);
                else passed++;
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_prescaled_down();
        test_single_step();
        test_priority();
        test_async_reset();
        test_wrap_mod2();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
